// File: rtl/gpu_command_issuer_if.sv
// Request/response channel from game logic bundled with the Snake card's instruction port.
// The issuer is the slave; game logic together with the card forms the master side.
interface gpu_command_issuer_if;
   logic        ReqValid;
   logic        ReqReady;
   logic [1:0]  ReqOp;
   logic [8:0]  ReqX0;
   logic [8:0]  ReqY0;
   logic [8:0]  ReqX1;
   logic [8:0]  ReqY1;
   logic [2:0]  ReqColor;
   logic        RspValid;
   logic [2:0]  RspData;
   logic        RspError;
   logic        GpuExecute;
   logic [24:0] GpuInstruction;
   logic [24:0] GpuDataOutput;
   logic        GpuReady;
   logic        Busy;

   modport slave (
      input  ReqValid, ReqOp, ReqX0, ReqY0, ReqX1, ReqY1, ReqColor, GpuDataOutput, GpuReady,
      output ReqReady, RspValid, RspData, RspError, GpuExecute, GpuInstruction, Busy
   );

   modport master (
      output ReqValid, ReqOp, ReqX0, ReqY0, ReqX1, ReqY1, ReqColor, GpuDataOutput, GpuReady,
      input  ReqReady, RspValid, RspData, RspError, GpuExecute, GpuInstruction, Busy
   );
endinterface

// File: rtl/gpu_command_issuer.sv
// Expands drawing requests (pixel, rectangle, clear, read) into Snake card instructions
// and issues them one at a time under the card's Ready handshake.
module gpu_command_issuer #(
   parameter int SCREEN_W       = 400,
   parameter int SCREEN_H       = 300,
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic               Clk,
   input  logic               Rst,
   gpu_command_issuer_if.slave bus
);
   localparam logic [1:0] OP_PIXEL = 2'd0;
   localparam logic [1:0] OP_RECT  = 2'd1;
   localparam logic [1:0] OP_CLEAR = 2'd2;
   localparam logic [1:0] OP_READ  = 2'd3;

   localparam logic [3:0] OPC_PUT   = 4'b0010;
   localparam logic [3:0] OPC_CLEAR = 4'b0100;
   localparam logic [3:0] OPC_STORE = 4'b0101;
   localparam logic [3:0] OPC_FILL  = 4'b0110;
   localparam logic [3:0] OPC_GET   = 4'b1000;

   localparam logic [9:0]  WIDTH_LIMIT  = 10'(SCREEN_W);
   localparam logic [9:0]  HEIGHT_LIMIT = 10'(SCREEN_H);
   localparam logic [20:0] TIMEOUT_LAST = 21'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, CHECK, ISSUE, ACK, WAIT, DONE} state_t;

   state_t      state;
   state_t      nextState;

   logic [1:0]  opReg;
   logic [2:0]  colorReg;
   logic [8:0]  x0Reg;
   logic [8:0]  y0Reg;
   logic [8:0]  x1Reg;
   logic [8:0]  y1Reg;
   logic [16:0] addrReg;
   logic        rangeErr;
   logic [2:0]  instrIndex;
   logic [20:0] timeoutCount;

   logic        gpuExecute;
   logic [24:0] gpuInstruction;
   logic        rspValid;
   logic [2:0]  rspData;
   logic        rspError;

   logic        accept;
   logic        issueFire;
   logic        waitDone;
   logic        finishError;
   logic [2:0]  lastIndex;
   logic [24:0] instrWord;

   logic        swapX;
   logic        swapY;
   logic [8:0]  x0Norm;
   logic [8:0]  y0Norm;
   logic [8:0]  x1Norm;
   logic [8:0]  y1Norm;
   logic [16:0] yExt;
   logic [16:0] addrNext;
   logic        rangeErrNext;
   logic        unusedDataBits;

   // Only the low three bits of the card result carry a pixel colour.
   assign unusedDataBits = ^bus.GpuDataOutput[24:3];

   // Request decode: rectangle corners are normalised and the linear address is y*400+x.
   always_comb begin
      swapX    = (bus.ReqOp == OP_RECT) && (bus.ReqX0 > bus.ReqX1);
      swapY    = (bus.ReqOp == OP_RECT) && (bus.ReqY0 > bus.ReqY1);
      x0Norm   = swapX ? bus.ReqX1 : bus.ReqX0;
      x1Norm   = swapX ? bus.ReqX0 : bus.ReqX1;
      y0Norm   = swapY ? bus.ReqY1 : bus.ReqY0;
      y1Norm   = swapY ? bus.ReqY0 : bus.ReqY1;
      yExt     = {8'd0, bus.ReqY0};
      addrNext = (yExt << 8) + (yExt << 7) + (yExt << 4) + {8'd0, bus.ReqX0};
      case (bus.ReqOp)
         OP_PIXEL, OP_READ:
            rangeErrNext = ({1'b0, bus.ReqX0} >= WIDTH_LIMIT) || ({1'b0, bus.ReqY0} >= HEIGHT_LIMIT);
         OP_RECT:
            rangeErrNext = ({1'b0, bus.ReqX0} >= WIDTH_LIMIT) || ({1'b0, bus.ReqY0} >= HEIGHT_LIMIT) ||
                           ({1'b0, bus.ReqX1} >= WIDTH_LIMIT) || ({1'b0, bus.ReqY1} >= HEIGHT_LIMIT);
         default:
            rangeErrNext = 1'b0;
      endcase
   end

   // Instruction word for the current position in the request's sequence.
   always_comb begin
      instrWord = '0;
      case (opReg)
         OP_PIXEL: instrWord = {1'b0, OPC_PUT, colorReg, addrReg};
         OP_READ:  instrWord = {1'b0, OPC_GET, 3'd0, addrReg};
         OP_CLEAR: instrWord = {1'b0, OPC_CLEAR, colorReg, 17'd0};
         default: begin
            case (instrIndex)
               3'd0:    instrWord = {1'b0, OPC_STORE, 3'd0, 8'd0, x0Reg};
               3'd1:    instrWord = {1'b0, OPC_STORE, 3'd1, 8'd0, y0Reg};
               3'd2:    instrWord = {1'b0, OPC_STORE, 3'd2, 8'd0, x1Reg};
               3'd3:    instrWord = {1'b0, OPC_STORE, 3'd3, 8'd0, y1Reg};
               default: instrWord = {1'b0, OPC_FILL, colorReg, 17'd0};
            endcase
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= IDLE;
      else      state <= nextState;
   end

   // Next state; Ready is deliberately not looked at in ACK so a stale Ready cannot end WAIT early.
   always_comb begin
      nextState   = state;
      accept      = 1'b0;
      issueFire   = 1'b0;
      waitDone    = 1'b0;
      finishError = 1'b0;
      lastIndex   = (opReg == OP_RECT) ? 3'd4 : 3'd0;
      case (state)
         IDLE: begin
            if (bus.ReqValid) begin
               accept    = 1'b1;
               nextState = CHECK;
            end
         end
         CHECK: begin
            if (rangeErr) begin
               finishError = 1'b1;
               nextState   = DONE;
            end else begin
               nextState = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.GpuReady) begin
               issueFire = 1'b1;
               nextState = ACK;
            end
         end
         ACK: nextState = WAIT;
         WAIT: begin
            if (bus.GpuReady) begin
               waitDone  = 1'b1;
               nextState = (instrIndex == lastIndex) ? DONE : ISSUE;
            end else if (timeoutCount >= TIMEOUT_LAST) begin
               finishError = 1'b1;
               nextState   = DONE;
            end
         end
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         opReg          <= '0;
         colorReg       <= '0;
         x0Reg          <= '0;
         y0Reg          <= '0;
         x1Reg          <= '0;
         y1Reg          <= '0;
         addrReg        <= '0;
         rangeErr       <= 1'b0;
         instrIndex     <= '0;
         timeoutCount   <= '0;
         gpuExecute     <= 1'b0;
         gpuInstruction <= '0;
         rspValid       <= 1'b0;
         rspData        <= '0;
         rspError       <= 1'b0;
      end else begin
         rspValid <= 1'b0;
         rspData  <= '0;
         rspError <= 1'b0;
         if (accept) begin
            opReg      <= bus.ReqOp;
            colorReg   <= bus.ReqColor;
            x0Reg      <= x0Norm;
            y0Reg      <= y0Norm;
            x1Reg      <= x1Norm;
            y1Reg      <= y1Norm;
            addrReg    <= addrNext;
            rangeErr   <= rangeErrNext;
            instrIndex <= '0;
         end
         if (issueFire) begin
            gpuExecute     <= 1'b1;
            gpuInstruction <= instrWord;
         end
         if (state == ACK) begin
            gpuExecute   <= 1'b0;
            timeoutCount <= '0;
         end
         if (state == WAIT && !waitDone && timeoutCount != '1) begin
            timeoutCount <= timeoutCount + 21'd1;
         end
         if (waitDone) begin
            instrIndex <= instrIndex + 3'd1;
         end
         // The response pulse covers exactly the DONE cycle; a read's data comes straight off the card.
         if (nextState == DONE && state != DONE) begin
            rspValid <= 1'b1;
            rspError <= finishError;
            rspData  <= (opReg == OP_READ && waitDone) ? bus.GpuDataOutput[2:0] : 3'd0;
         end
      end
   end

   assign bus.ReqReady       = (state == IDLE);
   assign bus.Busy           = (state != IDLE);
   assign bus.GpuExecute     = gpuExecute;
   assign bus.GpuInstruction = gpuInstruction;
   assign bus.RspValid       = rspValid;
   assign bus.RspData        = rspData;
   assign bus.RspError       = rspError;
endmodule

// File: tb/tb_gpu_command_issuer.sv
// Directed bench for gpu_command_issuer with a small behavioural Snake card model.
module tb_gpu_command_issuer;
   localparam logic [1:0] OP_PIXEL = 2'd0;
   localparam logic [1:0] OP_RECT  = 2'd1;
   localparam logic [1:0] OP_CLEAR = 2'd2;
   localparam logic [1:0] OP_READ  = 2'd3;

   logic        Clk;
   logic        Rst;
   logic        cardReady;
   logic        stallCard;
   logic        cardHang;
   int          cardDelay;
   logic [24:0] cardData;

   int          checks;
   int          errors;
   int          cycleCount;
   int          rspCount;
   int          rspBefore;
   int          acceptCycle;
   int          latency;
   int          mark;
   logic [24:0] strobeLog[$];
   int          strobeCyc[$];
   logic [2:0]  lastRspData;
   logic        lastRspError;
   logic [24:0] rectExp[5];

   gpu_command_issuer_if bus();

   assign bus.GpuReady = cardReady & ~stallCard;

   gpu_command_issuer #(
      .SCREEN_W(400),
      .SCREEN_H(300),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .Clk(Clk),
      .Rst(Rst),
      .bus(bus)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Card model: drops Ready after each strobe and raises it again after cardDelay edges.
   initial begin
      cardReady         = 1'b1;
      bus.GpuDataOutput = '0;
      forever begin
         @(posedge Clk);
         #1;
         if (bus.GpuExecute === 1'b1) begin
            cardReady = 1'b0;
            if (cardHang) begin
               while (cardHang) @(posedge Clk);
            end else begin
               repeat (cardDelay) @(posedge Clk);
            end
            #1;
            bus.GpuDataOutput = cardData;
            cardReady         = 1'b1;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(negedge Clk);
      cycleCount++;
      if (bus.GpuExecute === 1'b1) begin
         strobeLog.push_back(bus.GpuInstruction);
         strobeCyc.push_back(cycleCount);
      end
      if (bus.RspValid === 1'b1) begin
         rspCount++;
         lastRspData  = bus.RspData;
         lastRspError = bus.RspError;
      end
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic [8:0] x0, input logic [8:0] y0,
                                input logic [8:0] x1, input logic [8:0] y1, input logic [2:0] color);
      int n = 0;
      tick();
      bus.ReqOp    = op;
      bus.ReqX0    = x0;
      bus.ReqY0    = y0;
      bus.ReqX1    = x1;
      bus.ReqY1    = y1;
      bus.ReqColor = color;
      bus.ReqValid = 1'b1;
      while (bus.ReqReady !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      checkOutput("req_accepted", 32'(bus.ReqReady), 1);
      acceptCycle = cycleCount;
      @(posedge Clk);
      #1;
      bus.ReqValid = 1'b0;
   endtask

   task automatic waitRsp(input int maxCycles, output int lat);
      lat = -1;
      for (int i = 0; i < maxCycles; i++) begin
         tick();
         if (bus.RspValid === 1'b1) begin
            lat = cycleCount - acceptCycle;
            break;
         end
      end
      checkOutput("rsp_seen", 32'(lat >= 0), 1);
   endtask

   initial begin
      int n;
      checks       = 0;
      errors       = 0;
      cycleCount   = 0;
      rspCount     = 0;
      cardDelay    = 2;
      cardData     = '0;
      cardHang     = 1'b0;
      stallCard    = 1'b0;
      lastRspData  = '0;
      lastRspError = 1'b0;
      bus.ReqValid = 1'b0;
      bus.ReqOp    = '0;
      bus.ReqX0    = '0;
      bus.ReqY0    = '0;
      bus.ReqX1    = '0;
      bus.ReqY1    = '0;
      bus.ReqColor = '0;
      rectExp[0]   = {1'b0, 4'b0101, 3'd0, 17'd5};
      rectExp[1]   = {1'b0, 4'b0101, 3'd1, 17'd8};
      rectExp[2]   = {1'b0, 4'b0101, 3'd2, 17'd10};
      rectExp[3]   = {1'b0, 4'b0101, 3'd3, 17'd20};
      rectExp[4]   = {1'b0, 4'b0110, 3'd2, 17'd0};

      Rst = 1'b1;
      #1 Rst = 1'b0;
      #2;
      checkOutput("rst_req_ready", 32'(bus.ReqReady), 1);
      checkOutput("rst_rsp_valid", 32'(bus.RspValid), 0);
      checkOutput("rst_rsp_error", 32'(bus.RspError), 0);
      checkOutput("rst_rsp_data", 32'(bus.RspData), 0);
      checkOutput("rst_execute", 32'(bus.GpuExecute), 0);
      checkOutput("rst_instruction", 32'(bus.GpuInstruction), 0);
      checkOutput("rst_busy", 32'(bus.Busy), 0);
      tick();
      tick();
      Rst = 1'b1;
      tick();

      // Corner pixel: highest linear address.
      mark = strobeLog.size();
      applyStimulus(OP_PIXEL, 9'd399, 9'd299, 9'd0, 9'd0, 3'b101);
      tick();
      checkOutput("pixel_busy", 32'(bus.Busy), 1);
      checkOutput("pixel_not_ready", 32'(bus.ReqReady), 0);
      waitRsp(40, latency);
      checkOutput("pixel_strobes", strobeLog.size() - mark, 1);
      checkOutput("pixel_word", 32'(strobeLog[mark]), 32'({1'b0, 4'b0010, 3'b101, 17'd119999}));
      checkOutput("pixel_strobe_latency", strobeCyc[mark] - acceptCycle, 3);
      checkOutput("pixel_rsp_error", 32'(lastRspError), 0);
      checkOutput("pixel_rsp_data", 32'(lastRspData), 0);
      tick();
      checkOutput("pixel_ready_after", 32'(bus.ReqReady), 1);
      checkOutput("pixel_rsp_pulse", 32'(bus.RspValid), 0);

      // Card holds Ready low in ISSUE longer than the timeout: strobe waits, no error.
      stallCard = 1'b1;
      mark      = strobeLog.size();
      rspBefore = rspCount;
      applyStimulus(OP_PIXEL, 9'd123, 9'd45, 9'd0, 9'd0, 3'b011);
      repeat (20) tick();
      checkOutput("stall_no_strobe", strobeLog.size() - mark, 0);
      checkOutput("stall_no_rsp", rspCount - rspBefore, 0);
      checkOutput("stall_busy", 32'(bus.Busy), 1);
      stallCard = 1'b0;
      waitRsp(40, latency);
      checkOutput("stall_word", 32'(strobeLog[mark]), 32'({1'b0, 4'b0010, 3'b011, 17'd18123}));
      checkOutput("stall_rsp_error", 32'(lastRspError), 0);

      // Rectangle with both axes reversed.
      mark      = strobeLog.size();
      rspBefore = rspCount;
      applyStimulus(OP_RECT, 9'd10, 9'd20, 9'd5, 9'd8, 3'd2);
      waitRsp(80, latency);
      repeat (3) tick();
      checkOutput("rect_strobes", strobeLog.size() - mark, 5);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("rect_word%0d", i), 32'(strobeLog[mark + i]), 32'(rectExp[i]));
      end
      checkOutput("rect_rsp_count", rspCount - rspBefore, 1);
      checkOutput("rect_rsp_error", 32'(lastRspError), 0);

      // Pixel read.
      cardData = 25'd6;
      mark     = strobeLog.size();
      applyStimulus(OP_READ, 9'd0, 9'd0, 9'd0, 9'd0, 3'd0);
      waitRsp(40, latency);
      checkOutput("read_word", 32'(strobeLog[mark]), 32'({1'b0, 4'b1000, 3'd0, 17'd0}));
      checkOutput("read_data", 32'(lastRspData), 6);
      checkOutput("read_rsp_error", 32'(lastRspError), 0);
      cardData = '0;

      // Out-of-range pixel: immediate error, nothing issued.
      mark = strobeLog.size();
      applyStimulus(OP_PIXEL, 9'd400, 9'd10, 9'd0, 9'd0, 3'd1);
      waitRsp(20, latency);
      checkOutput("range_latency", latency, 2);
      checkOutput("range_rsp_error", 32'(lastRspError), 1);
      checkOutput("range_no_strobe", strobeLog.size() - mark, 0);

      // Out-of-range rectangle corner.
      mark = strobeLog.size();
      applyStimulus(OP_RECT, 9'd0, 9'd0, 9'd10, 9'd300, 3'd1);
      waitRsp(20, latency);
      checkOutput("rect_range_error", 32'(lastRspError), 1);
      checkOutput("rect_range_no_strobe", strobeLog.size() - mark, 0);

      // Card never answers a CLEAR: timeout after 16 WAIT cycles.
      cardHang = 1'b1;
      mark     = strobeLog.size();
      applyStimulus(OP_CLEAR, 9'd0, 9'd0, 9'd0, 9'd0, 3'b100);
      waitRsp(60, latency);
      checkOutput("timeout_latency", latency, 20);
      checkOutput("timeout_rsp_error", 32'(lastRspError), 1);
      checkOutput("timeout_strobes", strobeLog.size() - mark, 1);
      checkOutput("timeout_word", 32'(strobeLog[mark]), 32'({1'b0, 4'b0100, 3'b100, 17'd0}));
      tick();
      checkOutput("timeout_ready_after", 32'(bus.ReqReady), 1);
      cardHang = 1'b0;
      repeat (4) tick();

      // Reset while the third STORE of a rectangle is on the strobe.
      mark = strobeLog.size();
      applyStimulus(OP_RECT, 9'd1, 9'd2, 9'd3, 9'd4, 3'd5);
      n = 0;
      while ((strobeLog.size() - mark) < 3 && n < 60) begin
         tick();
         n++;
      end
      checkOutput("abort_third_store", 32'(strobeLog[mark + 2]), 32'({1'b0, 4'b0101, 3'd2, 17'd3}));
      rspBefore = rspCount;
      Rst = 1'b0;
      #1;
      checkOutput("abort_execute", 32'(bus.GpuExecute), 0);
      checkOutput("abort_instruction", 32'(bus.GpuInstruction), 0);
      checkOutput("abort_busy", 32'(bus.Busy), 0);
      checkOutput("abort_rsp_valid", 32'(bus.RspValid), 0);
      tick();
      tick();
      Rst = 1'b1;
      #1;
      checkOutput("abort_ready_after", 32'(bus.ReqReady), 1);
      repeat (15) tick();
      checkOutput("abort_no_rsp", rspCount - rspBefore, 0);
      checkOutput("abort_no_more_strobes", strobeLog.size() - mark, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
